// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ byte sources onto one UART transmitter with message locking and a tx_ready timeout.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16,
    parameter int PTR_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_req_last,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_grant,
    input  logic                 i_tx_ready,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_enable,
    output logic                 o_busy,
    output logic                 o_lock_active,
    output logic                 o_timeout_err
);

    localparam int SLOTS = 1 << PTR_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [SLOTS-1:0]   ONE_SLOT = {{(SLOTS-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] ONE_REQ  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || SLOTS < NUM_REQ || TIMEOUT < 1) begin : g_bad_cfg
            $error("uart_tx_arbiter: unsupported NUM_REQ/PTR_W/TIMEOUT combination");
        end
    endgenerate

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_SEND      = 4'b0010,
        ST_WAIT_BUSY = 4'b0100,
        ST_WAIT_DONE = 4'b1000
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data_nxt;
    logic               r_tx_enable;
    logic               w_tx_enable_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic               r_timeout_err;
    logic               w_timeout_err_nxt;
    logic               r_lock;
    logic               w_lock_nxt;
    logic               r_busy;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_rr_ptr_nxt;
`endif

    // Requester vectors padded to a power of two so PTR_W-wide indices always land in range.
    logic [SLOTS-1:0]   w_req_ext;
    logic [SLOTS-1:0]   w_last_ext;
    logic [SLOTS-1:0]   w_elig_ext;
    logic [7:0]         w_data_arr [SLOTS];
    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_idx;

    // Pad request, last and data buses out to SLOTS entries.
    always_comb begin
        w_req_ext  = '0;
        w_last_ext = '0;
        w_req_ext[NUM_REQ-1:0]  = i_req;
        w_last_ext[NUM_REQ-1:0] = i_req_last;
        for (int i = 0; i < SLOTS; i++) begin
            w_data_arr[i] = 8'h00;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_data_arr[i] = i_req_data[8*i +: 8];
        end
    end

    // While locked only the owner may be served.
    always_comb begin
        if (r_lock) begin
            w_elig_ext = w_req_ext & (ONE_SLOT << r_owner);
        end else begin
            w_elig_ext = w_req_ext;
        end
    end

    // Winner search over the eligible set.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'(k);
            if (!w_found && w_elig_ext[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig_ext[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end else begin
                w_found  = w_found;
            end
        end
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_tx_data_nxt     = r_tx_data;
        w_tx_enable_nxt   = 1'b0;
        w_grant_nxt       = '0;
        w_timeout_err_nxt = 1'b0;
        w_lock_nxt        = r_lock;
        w_owner_nxt       = r_owner;
        w_cnt_nxt         = r_cnt;
`ifndef UART_ARB_FIXED_PRIO_EN
        w_rr_ptr_nxt      = r_rr_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_lock && !w_req_ext[r_owner]) begin
                    // Owner abandoned its message: free the channel, serve nobody this cycle.
                    w_lock_nxt = 1'b0;
                end else if (i_tx_ready && w_found) begin
                    w_state_nxt     = ST_SEND;
                    w_tx_enable_nxt = 1'b1;
                    w_grant_nxt     = ONE_REQ << w_winner;
                    w_tx_data_nxt   = w_data_arr[w_winner];
`ifndef UART_ARB_FIXED_PRIO_EN
                    w_rr_ptr_nxt    = w_winner;
`endif
                    if (w_last_ext[w_winner]) begin
                        w_lock_nxt = 1'b0;
                    end else begin
                        w_lock_nxt  = 1'b1;
                        w_owner_nxt = w_winner;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_BUSY;
                w_cnt_nxt   = '0;
            end
            ST_WAIT_BUSY: begin
                if (!i_tx_ready) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt       = ST_IDLE;
                    w_timeout_err_nxt = 1'b1;
                    w_lock_nxt        = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lock_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tx_data     <= 8'h00;
            r_tx_enable   <= 1'b0;
            r_grant       <= '0;
            r_timeout_err <= 1'b0;
            r_lock        <= 1'b0;
            r_busy        <= 1'b0;
            r_owner       <= '0;
            r_cnt         <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            r_rr_ptr      <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_enable   <= w_tx_enable_nxt;
            r_grant       <= w_grant_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_lock        <= w_lock_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_owner       <= w_owner_nxt;
            r_cnt         <= w_cnt_nxt;
`ifndef UART_ARB_FIXED_PRIO_EN
            r_rr_ptr      <= w_rr_ptr_nxt;
`endif
        end
    end

    assign o_grant       = r_grant;
    assign o_tx_data     = r_tx_data;
    assign o_tx_enable   = r_tx_enable;
    assign o_busy        = r_busy;
    assign o_lock_active = r_lock;
    assign o_timeout_err = r_timeout_err;

endmodule
